// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and default sizing.
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_N        = 8;
    localparam int DEF_W        = 3;
    localparam int DEF_MAX_HOLD = 15;
    localparam int DEF_HW       = 8;

endpackage

// File: rtl/rr_arbiter_if.sv
// Requester-side bundle of the round-robin arbiter: request/release in, grant out.
interface rr_arbiter_if
    import rr_arbiter_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant;
    logic [W-1:0] grantId;
    logic         grantValid;
    logic         timeout;

    modport master (
        output req, done,
        input  grant, grantId, grantValid, timeout
    );

    modport slave (
        input  req, done,
        output grant, grantId, grantValid, timeout
    );
endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational rotated priority encoder: first set request at or after ptr, wrapping mod N.
module rr_pick
    import rr_arbiter_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] pick,
    output logic         any
);
    logic [N-1:0] rot;
    logic [W-1:0] idx;

    // Rotate right by ptr; W-bit index arithmetic wraps because N is a power of two.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[W'(i) + ptr];
        end
    end

    // Scanning downwards lets the lowest set index win.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

    assign pick = idx + ptr;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant held until done, owner drop, or hold timeout.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int W        = DEF_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HW       = DEF_HW
) (
    input logic       clk,
    input logic       rst_n,
    rr_arbiter_if.slave bus
);
    state_t        state_q, state_d;
    logic [W-1:0]  ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [W-1:0]  id_q, id_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;

    logic [W-1:0]  pick;
    logic          any;
    logic          owner_req;
    logic          hold_hit;

    rr_pick #(.N(N), .W(W)) u_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    assign owner_req = bus.req[id_q];
    assign hold_hit  = (hold_q == HW'(MAX_HOLD));

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        id_d      = id_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
                    id_d    = pick;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.done || !owner_req || hold_hit) begin
                    grant_d   = '0;
                    id_d      = '0;
                    valid_d   = 1'b0;
                    ptr_d     = id_q + W'(1);
                    state_d   = IDLE;
                    // A release that coincides with done or owner drop is a normal release.
                    timeout_d = hold_hit && !bus.done && owner_req;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.grantId    = id_q;
    assign bus.grantValid = valid_q;
    assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter with N=8, MAX_HOLD=15.
module tb_rr_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_arbiter_if #(.N(8), .W(3)) bus ();

    rr_arbiter #(.N(8), .W(3), .MAX_HOLD(15), .HW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {grant, grantId, grantValid, timeout}.
    function automatic logic [12:0] exp_v(input logic valid, input logic [2:0] id, input logic to);
        logic [7:0] g;
        g = valid ? (8'd1 << id) : 8'd0;
        return {g, (valid ? id : 3'd0), valid, to};
    endfunction

    function automatic logic [12:0] obs_v();
        return {bus.grant, bus.grantId, bus.grantValid, bus.timeout};
    endfunction

    // Grant-shape invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (($countones(bus.grant) > 1) ||
                (bus.grantValid && (bus.grant !== (8'd1 << bus.grantId))) ||
                (!bus.grantValid && (bus.grant !== 8'd0))) begin
                errors++;
                $display("FAIL invariant grant=%b grantId=%0d grantValid=%b",
                         bus.grant, bus.grantId, bus.grantValid);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        rst_n    = 1'b0;
        bus.req  = 8'hFF;
        bus.done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b0, 3'd0, 1'b0)) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", obs, exp_v(1'b0, 3'd0, 1'b0));
        end
        bus.req = '0;
        rst_n   = 1'b1;
    endtask

    task automatic test_single();
        logic [12:0] obs;
        apply_reset();
        bus.req = 8'b0000_0100;
        tick();
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b1, 3'd2, 1'b0)) begin
            errors++;
            $display("FAIL single_grant got=%h want=%h", obs, exp_v(1'b1, 3'd2, 1'b0));
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b0, 3'd0, 1'b0)) begin
            errors++;
            $display("FAIL single_release got=%h want=%h", obs, exp_v(1'b0, 3'd0, 1'b0));
        end
        // ptr is now 3, so of requesters 2 and 3 the winner must be 3.
        bus.req = 8'b0000_1100;
        tick();
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b1, 3'd3, 1'b0)) begin
            errors++;
            $display("FAIL single_ptr3 got=%h want=%h", obs, exp_v(1'b1, 3'd3, 1'b0));
        end
    endtask

    task automatic test_alternate();
        logic [12:0] obs;
        logic [2:0]  id;
        apply_reset();
        bus.req = 8'b1000_0001;
        for (int k = 0; k < 4; k++) begin
            id = (k % 2 == 1) ? 3'd7 : 3'd0;
            tick();
            obs = obs_v();
            checks++;
            if (obs !== exp_v(1'b1, id, 1'b0)) begin
                errors++;
                $display("FAIL alternate_grant%0d got=%h want=%h", k, obs, exp_v(1'b1, id, 1'b0));
            end
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            obs = obs_v();
            checks++;
            if (obs !== exp_v(1'b0, 3'd0, 1'b0)) begin
                errors++;
                $display("FAIL alternate_gap%0d got=%h want=%h", k, obs, exp_v(1'b0, 3'd0, 1'b0));
            end
        end
    endtask

    task automatic test_wrap();
        logic [12:0] obs;
        logic [2:0]  id;
        apply_reset();
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            id = 3'(k % 8);
            tick();
            obs = obs_v();
            checks++;
            if (obs !== exp_v(1'b1, id, 1'b0)) begin
                errors++;
                $display("FAIL wrap_grant%0d got=%h want=%h", k, obs, exp_v(1'b1, id, 1'b0));
            end
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
        end
    endtask

    task automatic test_timeout();
        logic [12:0] obs;
        apply_reset();
        bus.req = 8'b0010_0000;
        // Grant edge plus 15 holding edges: grant visible for 16 cycles.
        for (int c = 0; c < 16; c++) begin
            tick();
            obs = obs_v();
            checks++;
            if (obs !== exp_v(1'b1, 3'd5, 1'b0)) begin
                errors++;
                $display("FAIL timeout_hold%0d got=%h want=%h", c, obs, exp_v(1'b1, 3'd5, 1'b0));
            end
        end
        tick();
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b0, 3'd0, 1'b1)) begin
            errors++;
            $display("FAIL timeout_pulse got=%h want=%h", obs, exp_v(1'b0, 3'd0, 1'b1));
        end
        tick();
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b1, 3'd5, 1'b0)) begin
            errors++;
            $display("FAIL timeout_regrant got=%h want=%h", obs, exp_v(1'b1, 3'd5, 1'b0));
        end

        // done on the very edge the hold limit is reached is a normal release.
        apply_reset();
        bus.req = 8'b0010_0000;
        repeat (16) tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b0, 3'd0, 1'b0)) begin
            errors++;
            $display("FAIL timeout_with_done got=%h want=%h", obs, exp_v(1'b0, 3'd0, 1'b0));
        end
    endtask

    task automatic test_owner_drop();
        logic [12:0] obs;
        apply_reset();
        bus.req = 8'b0100_1000;
        tick();
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b1, 3'd3, 1'b0)) begin
            errors++;
            $display("FAIL drop_grant3 got=%h want=%h", obs, exp_v(1'b1, 3'd3, 1'b0));
        end
        bus.req = 8'b1100_1001;
        tick();
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b1, 3'd3, 1'b0)) begin
            errors++;
            $display("FAIL drop_others_ignored got=%h want=%h", obs, exp_v(1'b1, 3'd3, 1'b0));
        end
        bus.req = 8'b0100_0000;
        tick();
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b0, 3'd0, 1'b0)) begin
            errors++;
            $display("FAIL drop_release got=%h want=%h", obs, exp_v(1'b0, 3'd0, 1'b0));
        end
        tick();
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b1, 3'd6, 1'b0)) begin
            errors++;
            $display("FAIL drop_grant6 got=%h want=%h", obs, exp_v(1'b1, 3'd6, 1'b0));
        end
    endtask

    task automatic test_done_idle();
        logic [12:0] obs;
        apply_reset();
        bus.req  = 8'b0001_0000;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b1, 3'd4, 1'b0)) begin
            errors++;
            $display("FAIL done_in_idle got=%h want=%h", obs, exp_v(1'b1, 3'd4, 1'b0));
        end
    endtask

    task automatic test_async_reset();
        logic [12:0] obs;
        apply_reset();
        bus.req = 8'b0000_0100;
        tick();
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b1, 3'd2, 1'b0)) begin
            errors++;
            $display("FAIL areset_pregrant got=%h want=%h", obs, exp_v(1'b1, 3'd2, 1'b0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b0, 3'd0, 1'b0)) begin
            errors++;
            $display("FAIL areset_immediate got=%h want=%h", obs, exp_v(1'b0, 3'd0, 1'b0));
        end
        bus.req = 8'h30;
        tick();
        rst_n = 1'b1;
        tick();
        obs = obs_v();
        checks++;
        if (obs !== exp_v(1'b1, 3'd4, 1'b0)) begin
            errors++;
            $display("FAIL areset_first_grant got=%h want=%h", obs, exp_v(1'b1, 3'd4, 1'b0));
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_wrap();
        test_timeout();
        test_owner_drop();
        test_done_idle();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
